// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
// Module  : ram_fifo_ctrl
// Brief   : Pointer/occupancy controller turning ram_2port (sync write, async
//           read) into a synchronous FIFO. Optional macro FIFO_ERR_FLAGS_EN
//           adds sticky overflow/underflow outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_we,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH-1:0] mem_r_addr
);

    localparam int                c_DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH + 1)'(c_DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_acc;
    logic                  w_pop_acc;

    // Flags come only from the registered count, never from push/pop.
    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push_acc = push & ~w_full & rst_n;
    assign w_pop_acc  = pop & ~w_empty & rst_n;

    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign mem_we     = w_push_acc;
    assign mem_w_addr = r_wr_ptr;
    assign mem_w_data = push_data;
    assign mem_r_addr = r_rd_ptr;

    // Pointers wrap naturally at ADDR_WIDTH bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push & w_full & ~w_pop_acc) begin
                r_overflow <= 1'b1;
            end
            if (pop & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

`default_nettype wire

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Sequencing controller that turns the team's two-port RAM (ram_2port: synchronous write, asynchronous read) into a synchronous FIFO.
- Owns the write/read pointers, occupancy count and full/empty flags.
- Drives the RAM's w_addr, r_addr and write_enable; the RAM's w_data and r_data connect directly between the producer/consumer and the RAM.
- Sits between one producer and one consumer in the same clock domain.

Parameters:
- ADDR_WIDTH, 3, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH (must match the attached RAM).
- DATA_WIDTH, 8, data width; only used for the lint-consistent pass-through of push_data into mem_w_data.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst_n  input  1  synchronous reset, active-low
- push  input  1  producer requests a write of push_data this cycle
- push_data  input  DATA_WIDTH  write data
- pop  input  1  consumer consumes the head entry this cycle
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- mem_w_addr  output  ADDR_WIDTH  to RAM w_addr
- mem_w_data  output  DATA_WIDTH  to RAM w_data, equals push_data
- mem_we  output  1  to RAM write_enable
- mem_r_addr  output  ADDR_WIDTH  to RAM r_addr; head-of-FIFO address

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0. mem_we is forced 0 combinationally while rst_n=0, so no RAM write occurs in a reset cycle.
- Reset mid-operation: all in-flight contents are discarded. A push or pop in the reset cycle has no effect.
- Accepted operations:
  - push_acc = push & ~full & rst_n
  - pop_acc = pop & ~empty & rst_n
- Write path: mem_we = push_acc (combinational); mem_w_addr = wr_ptr. The RAM captures data on the same edge; wr_ptr increments on that edge.
- Read path: mem_r_addr = rd_ptr (combinational). The head word is valid on RAM r_data whenever empty=0, with zero-cycle read latency. pop_acc increments rd_ptr on the edge, so the next word appears the following cycle.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0 (natural ADDR_WIDTH rollover).
- Count update:
  - push_acc only: +1
  - pop_acc only: -1
  - both: unchanged
- Flags: full = (count==DEPTH); empty = (count==0). Both are registered or derived from the registered count, with no combinational path from push/pop.
- State view (equivalent to the flags):
  - EMPTY -> PARTIAL on a push.
  - PARTIAL -> FULL on a push without pop at count=DEPTH-1.
  - PARTIAL -> EMPTY on a pop without push at count=1.
  - FULL -> PARTIAL on a pop.
- Boundary cases:
  - push while full, no pop: ignored; RAM not written; state unchanged.
  - push+pop while full: pop accepted. The push is ignored because full gates it, so count goes to DEPTH-1. The producer must retry.
  - pop while empty: ignored.
  - push+pop while empty: push only, no fall-through; count becomes 1.
  - push+pop in PARTIAL: both accepted; both pointers advance; count unchanged.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow (1) and underflow (1), both sticky, reset to 0 by rst_n only.
  - overflow sets on push & full & ~pop_acc.
  - underflow sets on pop & empty.
  - Neither alters FIFO operation.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan (ADDR_WIDTH=3, DEPTH=8):
- Reset, then idle: empty=1, full=0, count=0, mem_we=0, mem_r_addr=0. Assert rst_n=0 with push=1: no write, state stays at reset values.
- Push 0x10..0x17 on 8 consecutive cycles: count 1..8, full=1 after the 8th edge. A 9th push of 0xFF gives mem_we=0 and count=8; overflow=1 if the macro is defined.
- From full, pop 8 times: r_data reads 0x10..0x17 in order, empty=1 after the 8th edge. A 9th pop leaves count=0; underflow=1 if the macro is defined.
- Pointer wrap: push 5 / pop 5, then push 0xA0..0xA4. The writes land at addresses 5,6,7,0,1, and pops return 0xA0..0xA4 in order.
- Simultaneous push+pop:
  - at count=3: count stays 3 and both pointers advance.
  - at empty: count=1 and the head equals the pushed word on the next cycle.
  - at full: count=7 and the pushed data is not written.
- Reset mid-stream at count=4: after the edge, count=0, empty=1, pointers 0. A subsequent push 0x55 then pop returns 0x55.
